// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Fetches at pc, hands the word to decode, then steps or branches pc.
module pc_fetch_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       INSTR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_step;
  logic [ADDR_W-1:0] pc_nxt;
  logic              ack_fire;
  logic              hs_fire;

  assign imem_addr = pc;
  assign ack_fire  = imem_req & imem_ack;
  assign hs_fire   = instr_valid & instr_ready;
  assign pc_step   = branch_taken ? branch_offset
                                  : ADDR_W'(INSTR_BYTES);
  assign pc_nxt    = instr_pc + pc_step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (!halt) state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = VALID;
      end
      VALID: begin
        instr_valid = 1'b1;
        if (instr_ready) state_nxt = halt ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Acks are only honoured in REQ, so stray acks never touch the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (ack_fire) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (hs_fire) begin
        pc          <= pc_nxt;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized self-checking bench for pc_fetch_sequencer.
// The reference model tracks the expected pc and accepted count.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] fetch_count;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;
  logic [31:0] w_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  logic [31:0] held;

  logic [31:0] offs [7] = '{32'hFFFF_FFF0, 32'h10, 32'h100,
                            32'hFFFF_FEEC, 32'h0, 32'h3, 32'h0};
  bit          tk   [7] = '{1, 1, 1, 1, 0, 1, 0};

  always #5 clk = ~clk;

  pc_fetch_sequencer u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .fetch_count   (fetch_count)
  );

  // Second instance starts near the top of the address space.
  pc_fetch_sequencer #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk           (clk),
    .reset_n       (reset_n),
    .halt          (1'b0),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_req),
    .imem_rdata    (32'h1234_5678),
    .instr_valid   (w_valid),
    .instr         (w_instr),
    .instr_pc      (w_ipc),
    .instr_ready   (1'b1),
    .branch_taken  (1'b0),
    .branch_offset (32'h0),
    .fetch_count   (w_cnt)
  );

  task automatic test_reset();
    reset_n       = 1'b0;
    halt          = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    instr_ready   = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = '0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_req got=%b/%h want=0/0",
               imem_req, imem_addr);
    end
    tests++;
    if (instr_valid !== 1'b0 || instr !== 32'h0
        || instr_pc !== 32'h0 || fetch_count !== 32'h0) begin
      fails++;
      $display("FAIL reset_out got v=%b i=%h pc=%h c=%h want 0",
               instr_valid, instr, instr_pc, fetch_count);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_req got=%b/%h want=1/0",
               imem_req, imem_addr);
    end
    exp_pc  = 32'h0;
    exp_cnt = 32'h0;
  endtask

  task automatic test_wrap();
    tests++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_first got=%b/%h want=1/fffffffc",
               w_req, w_addr);
    end
    @(negedge clk);
    tests++;
    if (w_valid !== 1'b1 || w_ipc !== 32'hFFFF_FFFC
        || w_instr !== 32'h1234_5678) begin
      fails++;
      $display("FAIL wrap_valid got=%b/%h/%h want=1/fffffffc/12345678",
               w_valid, w_ipc, w_instr);
    end
    @(negedge clk);
    tests++;
    if (w_req !== 1'b1 || w_addr !== 32'h0 || w_cnt !== 32'd1) begin
      fails++;
      $display("FAIL wrap_second got=%b/%h/%0d want=1/0/1",
               w_req, w_addr, w_cnt);
    end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL req_hold got=%b/%h want=1/0",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 8; i++) begin
      imem_ack    = 1'b0;
      instr_ready = 1'b0;
      if (i % 2 == 0) begin
        tests++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0
            || imem_addr !== exp_pc) begin
          fails++;
          $display("FAIL seq_req[%0d] got=%b/%b/%h want=1/0/%h",
                   i, imem_req, instr_valid, imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        held       = imem_rdata;
      end else begin
        tests++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0
            || instr_pc !== exp_pc || instr !== held) begin
          fails++;
          $display("FAIL seq_val[%0d] got=%b/%b/%h/%h want=1/0/%h/%h",
                   i, instr_valid, imem_req, instr_pc, instr,
                   exp_pc, held);
        end
        instr_ready   = 1'b1;
        branch_taken  = 1'b0;
        branch_offset = $urandom;
        exp_pc        = exp_pc + 32'd4;
        exp_cnt       = exp_cnt + 32'd1;
      end
      @(negedge clk);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    tests++;
    if (fetch_count !== 32'd4 || imem_addr !== 32'h10) begin
      fails++;
      $display("FAIL seq_end got=%0d/%h want=4/10",
               fetch_count, imem_addr);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        fails++;
        $display("FAIL br_req[%0d] got=%b/%h want=1/%h",
                 i, imem_req, imem_addr, exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      held       = imem_rdata;
      @(negedge clk);
      imem_ack = 1'b0;
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc
          || instr !== held) begin
        fails++;
        $display("FAIL br_val[%0d] got=%b/%h/%h want=1/%h/%h",
                 i, instr_valid, instr_pc, instr, exp_pc, held);
      end
      instr_ready   = 1'b1;
      branch_taken  = tk[i];
      branch_offset = tk[i] ? offs[i] : $urandom;
      exp_pc  = exp_pc + (tk[i] ? offs[i] : 32'd4);
      exp_cnt = exp_cnt + 32'd1;
      @(negedge clk);
      instr_ready  = 1'b0;
      branch_taken = 1'b0;
    end
    tests++;
    if (imem_addr !== 32'h7 || fetch_count !== exp_cnt) begin
      fails++;
      $display("FAIL br_end got=%h/%0d want=7/%0d",
               imem_addr, fetch_count, exp_cnt);
    end
  endtask

  task automatic test_random(input int n);
    int   done;
    int   cyc;
    int   ack_left;
    int   rdy_left;
    logic holding;
    done     = 0;
    cyc      = 0;
    holding  = 1'b0;
    ack_left = $urandom_range(0, 3);
    rdy_left = 0;
    while (done < n && cyc < 2000) begin
      tests++;
      if (instr_valid !== holding) begin
        fails++;
        $display("FAIL rnd_valid got=%b want=%b",
                 instr_valid, holding);
      end
      tests++;
      if (fetch_count !== exp_cnt) begin
        fails++;
        $display("FAIL rnd_count got=%0d want=%0d",
                 fetch_count, exp_cnt);
      end
      imem_ack      = 1'b0;
      instr_ready   = 1'b0;
      branch_taken  = 1'($urandom);
      branch_offset = $urandom;
      imem_rdata    = $urandom;
      if (holding) begin
        tests++;
        if (imem_req !== 1'b0) begin
          fails++;
          $display("FAIL rnd_double_fetch got=%b want=0", imem_req);
        end
        tests++;
        if (instr_pc !== exp_pc || instr !== held) begin
          fails++;
          $display("FAIL rnd_hold got=%h/%h want=%h/%h",
                   instr_pc, instr, exp_pc, held);
        end
        imem_ack = ($urandom_range(0, 3) == 0);
        if (rdy_left == 0) begin
          instr_ready  = 1'b1;
          branch_taken = ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 1) == 1)
            branch_offset = $urandom;
          else
            branch_offset =
              (32'($urandom_range(0, 64)) - 32'd32) << 2;
          exp_pc   = exp_pc
                   + (branch_taken ? branch_offset : 32'd4);
          exp_cnt  = exp_cnt + 32'd1;
          done++;
          holding  = 1'b0;
          ack_left = $urandom_range(0, 3);
        end else begin
          rdy_left--;
        end
      end else begin
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
          fails++;
          $display("FAIL rnd_req got=%b/%h want=1/%h",
                   imem_req, imem_addr, exp_pc);
        end
        if (ack_left == 0) begin
          imem_ack = 1'b1;
          held     = imem_rdata;
          holding  = 1'b1;
          rdy_left = $urandom_range(0, 2);
        end else begin
          ack_left--;
        end
      end
      @(negedge clk);
      cyc++;
    end
    imem_ack     = 1'b0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    tests++;
    if (done < n) begin
      fails++;
      $display("FAIL rnd_timeout got=%0d want=%0d", done, n);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        fails++;
        $display("FAIL halt_req[%0d] got=%b/%h want=1/%h",
                 i, imem_req, imem_addr, exp_pc);
      end
      imem_ack   = (i == 1);
      imem_rdata = $urandom;
      held       = imem_rdata;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1 || instr !== held
        || instr_pc !== exp_pc) begin
      fails++;
      $display("FAIL halt_val got=%b/%h/%h want=1/%h/%h",
               instr_valid, instr, instr_pc, held, exp_pc);
    end
    instr_ready  = 1'b1;
    branch_taken = 1'b0;
    exp_pc       = exp_pc + 32'd4;
    exp_cnt      = exp_cnt + 32'd1;
    @(negedge clk);
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0
          || imem_addr !== exp_pc || fetch_count !== exp_cnt) begin
        fails++;
        $display("FAIL halt_park[%0d] got=%b/%b/%h/%0d want=0/0/%h/%0d",
                 i, imem_req, instr_valid, imem_addr, fetch_count,
                 exp_pc, exp_cnt);
      end
      @(negedge clk);
    end
    halt = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
      fails++;
      $display("FAIL halt_resume got=%b/%h want=1/%h",
               imem_req, imem_addr, exp_pc);
    end
  endtask

  task automatic test_async_reset();
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0
        || fetch_count !== 32'h0) begin
      fails++;
      $display("FAIL rst_req_phase got=%b/%h/%0d want=0/0/0",
               imem_req, imem_addr, fetch_count);
    end
    @(negedge clk);
    halt       = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0
        || instr !== 32'h0 || fetch_count !== 32'h0) begin
      fails++;
      $display("FAIL rst_spurious got=%b/%b/%h/%0d want=0/0/0/0",
               imem_req, instr_valid, instr, fetch_count);
    end
    imem_ack = 1'b0;
    halt     = 1'b0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_restart got=%b/%h want=1/0",
               imem_req, imem_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = $urandom | 32'h1;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL rst_val got=%b/%h want=1/0",
               instr_valid, instr_pc);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || instr !== 32'h0
        || instr_pc !== 32'h0 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_val_phase got=%b/%h/%h/%b want=0/0/0/0",
               instr_valid, instr, instr_pc, imem_req);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0
        || fetch_count !== 32'h0) begin
      fails++;
      $display("FAIL rst_resume got=%b/%h/%0d want=1/0/0",
               imem_req, imem_addr, fetch_count);
    end
    exp_pc  = 32'h0;
    exp_cnt = 32'h0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sequential();
    test_branch();
    test_random(40);
    test_halt();
    test_async_reset();
    test_random(15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
